// File: rtl/vc_credit_status.sv
// vc_credit_status
//   Tracks a downstream credit counter and a busy (allocated) flag for every
//   (output port, VC) pair of a router and exposes them as flat, one-hot
//   indexable status vectors. All outputs come straight from registers, so
//   there is no combinational path from any input to any output.
//
// Ports
//   clk, rst_n          router clock, asynchronous active-low reset
//   flit_sent           a flit left on (sent_port, sent_vc); sent_tail marks a tail
//   alloc_valid         VC allocator grant of (alloc_port, alloc_vc)
//   credit_valid[p]     credit return on port p for VC credit_vc[p*NV +: NV]
//   vc_blocked[p*NV+v]  credit counter of (p,v) is zero
//   vc_free[p*NV+v]     (p,v) is not allocated
//   err                 sticky protocol error, cleared only by reset
module vc_credit_status #(
  parameter int NP        = 5,
  parameter int NV        = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flit_sent,
  input  logic [NP-1:0]        sent_port,
  input  logic [NV-1:0]        sent_vc,
  input  logic                 sent_tail,
  input  logic                 alloc_valid,
  input  logic [NP-1:0]        alloc_port,
  input  logic [NV-1:0]        alloc_vc,
  input  logic [NP-1:0]        credit_valid,
  input  logic [NP*NV-1:0]     credit_vc,
  output logic [NP*NV-1:0]     vc_blocked,
  output logic [NP*NV-1:0]     vc_free,
  output logic                 err
);

  localparam int NE = NP * NV;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);

  // A strobe whose selects are not exactly one-hot is dropped as a whole
  // and only flags the error.
  logic send_ok, send_err;
  logic alloc_ok, alloc_err;
  logic [NP-1:0] cred_ok, cred_err;
  logic [NE-1:0] entry_err;
  logic err_reg, err_next;

  assign send_ok   = flit_sent & $onehot(sent_port) & $onehot(sent_vc);
  assign send_err  = flit_sent & ~send_ok;
  assign alloc_ok  = alloc_valid & $onehot(alloc_port) & $onehot(alloc_vc);
  assign alloc_err = alloc_valid & ~alloc_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      assign cred_ok[gi]  = credit_valid[gi] & $onehot(credit_vc[gi*NV +: NV]);
      assign cred_err[gi] = credit_valid[gi] & ~cred_ok[gi];
    end

    for (gi = 0; gi < NE; gi++) begin : g_entry
      localparam int P = gi / NV;
      localparam int V = gi % NV;

      logic          dec, inc, alloc, rel;
      logic [CW-1:0] credit_reg, credit_next;
      logic          busy_reg, busy_next;
      logic          err_hit;

      assign dec   = send_ok & sent_port[P] & sent_vc[V];
      assign inc   = cred_ok[P] & credit_vc[gi];
      assign alloc = alloc_ok & alloc_port[P] & alloc_vc[V];
      assign rel   = dec & sent_tail;

      always_comb begin
        credit_next = credit_reg;
        busy_next   = busy_reg;
        err_hit     = 1'b0;
        // A simultaneous send and return cancel out.
        if (dec && !inc) begin
          if (credit_reg == '0) err_hit = 1'b1;
          else                  credit_next = credit_reg - CW'(1);
        end else if (inc && !dec) begin
          if (credit_reg == CREDIT_MAX) err_hit = 1'b1;
          else                          credit_next = credit_reg + CW'(1);
        end
        // Allocation wins over a same-cycle release, but that is still an error.
        if (alloc) begin
          if (busy_reg || rel) err_hit = 1'b1;
          busy_next = 1'b1;
        end else if (rel) begin
          if (!busy_reg) err_hit = 1'b1;
          busy_next = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          credit_reg <= CREDIT_MAX;
          busy_reg   <= 1'b0;
        end else begin
          credit_reg <= credit_next;
          busy_reg   <= busy_next;
        end
      end

      assign entry_err[gi]  = err_hit;
      assign vc_blocked[gi] = (credit_reg == '0);
      assign vc_free[gi]    = ~busy_reg;
    end
  endgenerate

  assign err_next = err_reg | send_err | alloc_err | (|cred_err) | (|entry_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= err_next;
  end

  assign err = err_reg;

endmodule

// File: tb/tb_vc_credit_status.sv
module tb_vc_credit_status;

  localparam int NP = 5;
  localparam int NV = 4;
  localparam int BD = 4;
  localparam int CW = 3;
  localparam int N  = NP * NV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flit_sent;
  logic [NP-1:0] sent_port;
  logic [NV-1:0] sent_vc;
  logic          sent_tail;
  logic          alloc_valid;
  logic [NP-1:0] alloc_port;
  logic [NV-1:0] alloc_vc;
  logic [NP-1:0] credit_valid;
  logic [N-1:0]  credit_vc;
  logic [N-1:0]  vc_blocked;
  logic [N-1:0]  vc_free;
  logic          err;

  always #5 clk = ~clk;

  vc_credit_status #(.NP(NP), .NV(NV), .BUF_DEPTH(BD), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_sent(flit_sent), .sent_port(sent_port), .sent_vc(sent_vc), .sent_tail(sent_tail),
    .alloc_valid(alloc_valid), .alloc_port(alloc_port), .alloc_vc(alloc_vc),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .vc_blocked(vc_blocked), .vc_free(vc_free), .err(err)
  );

  typedef struct packed {
    logic [N-1:0] blk;
    logic [N-1:0] fr;
    logic         e;
  } exp_t;

  int   m_cnt [N];
  bit   m_busy[N];
  bit   m_err;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model_view();
    exp_t r;
    for (int i = 0; i < N; i++) begin
      r.blk[i] = (m_cnt[i] == 0);
      r.fr[i]  = !m_busy[i];
    end
    r.e = m_err;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = BD;
      m_busy[i] = 0;
    end
    m_err = 0;
  endtask

  // Applies the currently driven strobes to the model and queues the result
  // the DUT must show after the next rising edge.
  task automatic model_step();
    bit s_ok, a_ok;
    bit c_ok[NP];
    s_ok = flit_sent && ($countones(sent_port) == 1) && ($countones(sent_vc) == 1);
    a_ok = alloc_valid && ($countones(alloc_port) == 1) && ($countones(alloc_vc) == 1);
    if (flit_sent && !s_ok) m_err = 1;
    if (alloc_valid && !a_ok) m_err = 1;
    for (int p = 0; p < NP; p++) begin
      c_ok[p] = credit_valid[p] && ($countones(credit_vc[p*NV +: NV]) == 1);
      if (credit_valid[p] && !c_ok[p]) m_err = 1;
    end
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        int i;
        bit dec, inc, al, rl;
        i   = p * NV + v;
        dec = s_ok && sent_port[p] && sent_vc[v];
        inc = c_ok[p] && credit_vc[i];
        al  = a_ok && alloc_port[p] && alloc_vc[v];
        rl  = dec && sent_tail;
        if (dec && !inc) begin
          if (m_cnt[i] == 0) m_err = 1; else m_cnt[i]--;
        end else if (inc && !dec) begin
          if (m_cnt[i] == BD) m_err = 1; else m_cnt[i]++;
        end
        if (al) begin
          if (m_busy[i] || rl) m_err = 1;
          m_busy[i] = 1;
        end else if (rl) begin
          if (!m_busy[i]) m_err = 1;
          m_busy[i] = 0;
        end
      end
    end
    sb_q.push_back(model_view());
  endtask

  task automatic check_all(string tag, exp_t exp);
    exp_t obs;
    obs = {vc_blocked, vc_free, err};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got blk=%h free=%h err=%b, expected blk=%h free=%h err=%b",
             tag, obs.blk, obs.fr, obs.e, exp.blk, exp.fr, exp.e);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flit_sent    = 0; sent_port  = '0; sent_vc  = '0; sent_tail = 0;
    alloc_valid  = 0; alloc_port = '0; alloc_vc = '0;
    credit_valid = '0; credit_vc = '0;
  endtask

  task automatic set_send(int p, int v, bit tail);
    flit_sent = 1; sent_port = '0; sent_vc = '0;
    sent_port[p] = 1'b1; sent_vc[v] = 1'b1; sent_tail = tail;
  endtask

  task automatic set_alloc(int p, int v);
    alloc_valid = 1; alloc_port = '0; alloc_vc = '0;
    alloc_port[p] = 1'b1; alloc_vc[v] = 1'b1;
  endtask

  task automatic set_credit(int p, int v);
    credit_valid[p] = 1'b1;
    credit_vc[p*NV +: NV] = '0;
    credit_vc[p*NV + v] = 1'b1;
  endtask

  // One transaction: model the driven strobes, clock once, compare, go idle.
  task automatic step(string tag);
    exp_t exp;
    model_step();
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_all(tag, exp);
    $display("[TB] %-12s blk=%h free=%h err=%b", tag, vc_blocked, vc_free, err);
    clear_inputs();
  endtask

  // Reset asserted asynchronously while a send is being driven.
  task automatic do_reset(string tag);
    exp_t rst_exp;
    rst_exp.blk = '0;
    rst_exp.fr  = '1;
    rst_exp.e   = 1'b0;
    set_send(0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    check_all(tag, rst_exp);
    $display("[TB] %-12s blk=%h free=%h err=%b", tag, vc_blocked, vc_free, err);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    #12;
    begin
      exp_t r0;
      r0.blk = '0; r0.fr = '1; r0.e = 1'b0;
      check_all("reset", r0);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Drain port2/VC1 (bit 9), then refill with one credit.
    for (int k = 0; k < 4; k++) begin
      set_send(2, 1, 0);
      step("drain");
    end
    check_bit("blocked9_hi", vc_blocked[9], 1'b1);
    set_credit(2, 1);
    step("refill");
    check_bit("blocked9_lo", vc_blocked[9], 1'b0);
    check_bit("err_after_refill", err, 1'b0);

    // count is 1; one more credit -> 2, then send+credit together keeps 2.
    set_credit(2, 1);
    step("to_two");
    set_send(2, 1, 0); set_credit(2, 1);
    step("send_cred");
    set_send(2, 1, 0);
    step("dec_one");
    check_bit("blocked9_cnt1", vc_blocked[9], 1'b0);
    set_send(2, 1, 0);
    step("dec_zero");
    check_bit("blocked9_cnt0", vc_blocked[9], 1'b1);
    for (int k = 0; k < 4; k++) begin
      set_credit(2, 1);
      step("restore");
    end

    // One send on VC0 of every port, then all ports return at once.
    for (int p = 0; p < NP; p++) begin
      set_send(p, 0, 0);
      step("send_vc0");
    end
    for (int p = 0; p < NP; p++) set_credit(p, 0);
    step("all_credit");

    // Ownership of port0/VC3.
    set_alloc(0, 3);
    step("alloc");
    check_bit("free3_lo", vc_free[3], 1'b0);
    set_send(0, 3, 0);
    step("body");
    set_credit(0, 3);
    set_send(0, 3, 0);
    step("body2");
    check_bit("free3_body", vc_free[3], 1'b0);
    set_send(0, 3, 1);
    step("tail");
    check_bit("free3_hi", vc_free[3], 1'b1);
    check_bit("err_clean", err, 1'b0);
    set_credit(0, 3);
    step("cred03");
    set_alloc(0, 3);
    step("alloc_again");
    set_alloc(0, 3);
    step("alloc_busy");
    check_bit("err_alloc_busy", err, 1'b1);
    step("idle");
    check_bit("err_sticky", err, 1'b1);

    // Underflow: fifth send to port1/VC0.
    do_reset("reset_mid1");
    for (int k = 0; k < 5; k++) begin
      set_send(1, 0, 0);
      step("underflow");
    end
    check_bit("err_underflow", err, 1'b1);

    // Overflow: credit on a full counter.
    do_reset("reset_mid2");
    set_credit(3, 2);
    step("overflow");
    check_bit("err_overflow", err, 1'b1);

    // Non one-hot send port: no counter change, err set.
    do_reset("reset_mid3");
    flit_sent = 1; sent_port = 5'b00011; sent_vc = 4'b0001;
    step("bad_port");
    for (int k = 0; k < 4; k++) begin
      set_send(0, 0, 0);
      step("post_bad");
    end

    // Alloc and tail release on same VC same cycle.
    do_reset("reset_mid4");
    set_alloc(4, 2); set_send(4, 2, 1);
    step("alloc_rel");
    check_bit("err_alloc_rel", err, 1'b1);
    check_bit("free18_lo", vc_free[18], 1'b0);

    // Release of an unallocated VC, and a bad credit slice.
    do_reset("reset_mid5");
    set_send(3, 1, 1);
    step("rel_free");
    do_reset("reset_mid6");
    set_send(2, 2, 0);
    step("pre_badcred");
    credit_valid[2] = 1'b1; credit_vc[2*NV +: NV] = 4'b0110;
    set_credit(1, 0);
    step("bad_cred");

    // Random legal traffic.
    do_reset("reset_rand");
    for (int c = 0; c < 10000; c++) begin
      int p, v, i;
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, NP - 1); v = $urandom_range(0, NV - 1); i = p * NV + v;
        if (m_cnt[i] > 0) set_send(p, v, m_busy[i] ? bit'($urandom_range(0, 1)) : 1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, NP - 1); v = $urandom_range(0, NV - 1); i = p * NV + v;
        if (!m_busy[i] && !(flit_sent && sent_tail && sent_port[p] && sent_vc[v]))
          set_alloc(p, v);
      end
      for (int q = 0; q < NP; q++) begin
        if ($urandom_range(0, 2) == 0) begin
          v = $urandom_range(0, NV - 1);
          if (m_cnt[q * NV + v] < BD) set_credit(q, v);
        end
      end
      step("rand");
    end
    check_bit("err_rand", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vc_credit_status.md
# vc_credit_status

Per-router output-VC credit and ownership tracker. It maintains a credit counter and a free/busy flag for every (output port, VC) pair. From these it drives the flat blocked-status vector and the free-VC vector that the router's unary pair-select logic and VC allocator index with one-hot port and VC selects. It sits between the switch traversal stage, which reports flits sent, and the downstream credit return links.

## Interface
- NP, 5, number of output ports
- NV, 4, VCs per port
- BUF_DEPTH, 4, downstream buffer depth per VC; credit reset value; must be ≥1
- CW, 3, credit counter width; must satisfy 2^CW > BUF_DEPTH
- clk  in  1  router clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flit_sent  in  1  a flit left on (sent_port, sent_vc) this cycle
- sent_port  in  NP  one-hot output port of sent flit
- sent_vc  in  NV  one-hot VC of sent flit
- sent_tail  in  1  sent flit is a tail (qualified by flit_sent)
- alloc_valid  in  1  VC allocator grants (alloc_port, alloc_vc) this cycle
- alloc_port  in  NP  one-hot
- alloc_vc  in  NV  one-hot
- credit_valid  in  NP  per-port credit return strobe
- credit_vc  in  NP*NV  per-port one-hot VC of returned credit, port p at [p*NV +: NV]
- vc_blocked  out  NP*NV  bit p*NV+v = 1 when credit[p][v]==0
- vc_free  out  NP*NV  bit p*NV+v = 1 when VC is unallocated
- err  out  1  sticky protocol-error flag

## Operation
- State: credit[p][v] (CW bits), busy[p][v], err. Outputs are decoded purely from registers: no combinational path from any input to any output.
- **Credit update per (p,v):**
  - dec = flit_sent & sent_port[p] & sent_vc[v]
  - inc = credit_valid[p] & credit_vc[p*NV+v]
  - inc & dec: count unchanged.
  - dec only: count −1.
  - inc only: count +1.
- **Underflow:** dec only with count==0 leaves count at 0 and sets err.
- **Overflow:** inc only with count==BUF_DEPTH leaves count at BUF_DEPTH and sets err.
- **Ownership per (p,v):**
  - alloc = alloc_valid & alloc_port[p] & alloc_vc[v] sets busy.
  - rel = dec & sent_tail clears busy.
  - alloc to an already-busy VC sets err; VC stays busy.
  - alloc & rel same cycle, same VC: err set, busy stays 1. Allocation wins.
  - rel on a VC that is not busy: busy stays 0, err set.
- **One-hot checks:**
  - If flit_sent=1 and sent_port or sent_vc is not exactly one-hot, the send event is discarded entirely (no dec, no rel) and err is set.
  - The same rule applies to alloc_valid with alloc_port/alloc_vc.
  - The same rule applies to credit_valid[p] with its credit_vc slice; only that port's event is discarded.
- Events to different (p,v) in the same cycle are independent. All NP credit links may return simultaneously.
- err is cleared only by rst_n.

## Timing
- **Reset (async assert, sync-safe deassert by system):**
  - credit = BUF_DEPTH for all entries.
  - busy = 0.
  - err = 0.
  - Hence vc_blocked = all 0 and vc_free = all 1.
- **Latency:** an event sampled at edge N is visible on vc_blocked/vc_free/err after edge N. This is one cycle, with no bypass.
- **Blocking example:** BUF_DEPTH sends to one VC with no returns make its blocked bit go high right after the edge of the last send. The first returned credit clears it after that credit's edge.
- **Reset mid-operation:** all state returns to reset values immediately on rst_n low, regardless of pending events. Events in the cycle of deassertion edge are ignored.
- No handshakes. Every input is a single-cycle strobe, sampled every cycle it is high.

## Test plan
- **Reset:** assert rst_n=0 mid-traffic → vc_blocked=0x00000, vc_free=0xFFFFF, err=0 immediately (NP=5, NV=4).
- **Drain and refill:** 4 sends to port2/VC1 on consecutive cycles, no credits → bit 9 of vc_blocked high after 4th edge. One credit on credit_valid[2], credit_vc slice 0010 → bit 9 low next cycle. err stays 0.
- **Simultaneous:** at count=2, send and credit to same VC same cycle → count stays 2. All 5 ports return credits to VC0 at once after 1 send each → all counts back to 4.
- **Ownership:** alloc port0/VC3 → vc_free bit 3 low. Body flits keep it low. Tail send → bit 3 high next cycle. Alloc again same VC while busy → err=1 and stays 1.
- **Error saturation:** send at count 0 → count 0, err=1. Credit at count 4 → count 4, err=1. sent_port=00011 with flit_sent → no counter change, err=1.
- **Randomized:** random legal traffic vs scoreboard model of counts and busy flags, 10k cycles → outputs match every cycle, err=0.
